// File: rtl/intpol2_d4_mult_ctrl_pkg.sv
// Shared definitions for the quadratic-interpolator multiplier sequencer.
// Holds the datapath widths, the interpolation step geometry, the FSM state
// encoding, the coefficient payload struct and the saturation helper.
// Optional feature macro: INTPOL2_SAT_EN (saturating output sum).
package intpol2_d4_mult_ctrl_pkg;

    localparam int unsigned DATAPATH_WIDTH = 32;
    localparam int unsigned N_BITS         = 2;
    localparam int unsigned M_BITS         = 31;
    localparam int unsigned LOG2_STEPS     = 2;

    localparam int unsigned W         = DATAPATH_WIDTH + N_BITS;
    localparam int unsigned SUM_W     = W + 2;
    localparam int unsigned STEPS     = 1 << LOG2_STEPS;
    localparam int unsigned K2_W      = 2 * LOG2_STEPS;
    localparam int unsigned XI_SHIFT  = M_BITS - LOG2_STEPS;
    localparam int unsigned XI2_SHIFT = M_BITS - 2 * LOG2_STEPS;

    // Saturation bounds, both at output width and sign-extended to the sum width
    localparam logic signed [W-1:0]     SAT_MAX     = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]     SAT_MIN     = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] SAT_MAX_EXT = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN_EXT = {3'b111, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL_A = 2'd1,
        ST_MUL_B = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    typedef struct packed {
        logic signed [W-1:0] p0;
        logic signed [W-1:0] p1;
        logic signed [W-1:0] p2;
    } coef_t;

    // Clamp a wide sum into W bits; MSB of the result is the clamp flag
    function automatic logic [W:0] sat_reduce(input logic signed [SUM_W-1:0] s);
        if (s > SAT_MAX_EXT) begin
            return {1'b1, SAT_MAX};
        end else if (s < SAT_MIN_EXT) begin
            return {1'b1, SAT_MIN};
        end
        return {1'b0, s[W-1:0]};
    endfunction

endpackage

// File: rtl/intpol2_d4_mult_ctrl_xi_gen.sv
// Interpolation abscissa generator.
// Tracks k and k^2 (k^2 updated incrementally as k2 += 2k+1, no multiplier)
// and presents xi = k << XI_SHIFT and xi2 = k^2 << XI2_SHIFT.
// Ports:
//   clk_i, rstn_i  clock, synchronous active-low reset
//   clr_i          restart at k = 0 (coefficient load)
//   step_i         advance to k+1 (output handshake)
//   last_c_o       k is the last step of the set (decode of k register)
//   xi_o, xi2_o    multiplier operands, unsigned values in signed W
module intpol2_d4_mult_ctrl_xi_gen
    import intpol2_d4_mult_ctrl_pkg::*;
(
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                clr_i,
    input  logic                step_i,
    output logic                last_c_o,
    output logic signed [W-1:0] xi_o,
    output logic signed [W-1:0] xi2_o
);

    logic [LOG2_STEPS-1:0] k_q, k_d;
    logic [K2_W-1:0]       k2_q, k2_d;

    // Next k / k^2; stepping past the last point wraps both back to zero
    always_comb begin
        k_d  = k_q;
        k2_d = k2_q;
        if (clr_i) begin
            k_d  = '0;
            k2_d = '0;
        end else if (step_i) begin
            k_d  = k_q + LOG2_STEPS'(1);
            k2_d = k2_q + K2_W'({k_q, 1'b1});
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            k_q  <= '0;
            k2_q <= '0;
        end else begin
            k_q  <= k_d;
            k2_q <= k2_d;
        end
    end

    assign last_c_o = (k_q == LOG2_STEPS'(STEPS - 1));
    assign xi_o     = W'({k_q, XI_SHIFT'(0)});
    assign xi2_o    = W'({k2_q, XI2_SHIFT'(0)});

endmodule

// File: rtl/intpol2_d4_mult_ctrl.sv
// Sequencer for the shared quadratic-interpolator multiplier.
// Per accepted coefficient set (p0,p1,p2) it produces STEPS samples
// y = p0 + p1*xi + p2*xi^2, xi = k/STEPS, using the external multiplier twice
// per sample: MUL_A computes p1*xi, MUL_B computes p2*xi^2.
// Optional feature macro: INTPOL2_SAT_EN -- saturate the sum and add sat_flag_o;
// when undefined the sum wraps to W bits.
// Ports:
//   clk_i, rstn_i               clock, synchronous active-low reset
//   coef_valid_i/coef_ready_o   coefficient stream handshake
//   p0_i, p1_i, p2_i            signed coefficients (Q.M_BITS)
//   sel_mult_o                  0 = (p1,xi), 1 = (p2,xi2)
//   mult_xi_o, mult_xi2_o       abscissa operands
//   mult_p1_o, mult_p2_o        registered coefficient operands
//   mult_data_i                 multiplier result (combinational from operands)
//   y_valid_o/y_ready_i/y_data_o output sample stream
//   busy_o                      high whenever not idle
//   sat_flag_o                  clamp indicator (INTPOL2_SAT_EN only)
module intpol2_d4_mult_ctrl
    import intpol2_d4_mult_ctrl_pkg::*;
(
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                coef_valid_i,
    output logic                coef_ready_o,
    input  logic signed [W-1:0] p0_i,
    input  logic signed [W-1:0] p1_i,
    input  logic signed [W-1:0] p2_i,
    output logic                sel_mult_o,
    output logic signed [W-1:0] mult_xi_o,
    output logic signed [W-1:0] mult_xi2_o,
    output logic signed [W-1:0] mult_p1_o,
    output logic signed [W-1:0] mult_p2_o,
    input  logic signed [W-1:0] mult_data_i,
    output logic                y_valid_o,
    input  logic                y_ready_i,
    output logic signed [W-1:0] y_data_o,
`ifdef INTPOL2_SAT_EN
    output logic                sat_flag_o,
`endif
    output logic                busy_o
);

    state_e              state_q, state_d;
    coef_t               coef_q;
    logic signed [W-1:0] t1_q;
    logic signed [W-1:0] y_data_q;
    logic signed [W-1:0] y_next_c;
    logic                coef_ready_q, sel_mult_q, y_valid_q, busy_q;
    logic                load_c, step_c, cap_t1_c, cap_y_c, last_c;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes
    always_comb begin
        state_d  = state_q;
        load_c   = 1'b0;
        step_c   = 1'b0;
        cap_t1_c = 1'b0;
        cap_y_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (coef_valid_i) begin
                    load_c  = 1'b1;
                    state_d = ST_MUL_A;
                end
            end
            ST_MUL_A: begin
                cap_t1_c = 1'b1;
                state_d  = ST_MUL_B;
            end
            ST_MUL_B: begin
                cap_y_c = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (y_ready_i) begin
                    step_c  = 1'b1;
                    state_d = last_c ? ST_IDLE : ST_MUL_A;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control outputs registered from the next state so they align with it
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            coef_ready_q <= 1'b1;
            sel_mult_q   <= 1'b0;
            y_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            coef_ready_q <= (state_d == ST_IDLE);
            sel_mult_q   <= (state_d == ST_MUL_B);
            y_valid_q    <= (state_d == ST_OUT);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

`ifdef INTPOL2_SAT_EN
    logic signed [SUM_W-1:0] sum_c;
    logic                    sat_next_c;
    logic                    sat_q;

    // Wide sum cannot overflow; clamp back into W bits
    always_comb begin
        sum_c = SUM_W'($signed(coef_q.p0)) + SUM_W'(t1_q) + SUM_W'(mult_data_i);
        {sat_next_c, y_next_c} = sat_reduce(sum_c);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            sat_q <= 1'b0;
        end else if (cap_y_c) begin
            sat_q <= sat_next_c;
        end
    end

    assign sat_flag_o = sat_q;
`else
    // Low W bits of the wide sum are exactly the W-bit modular sum
    assign y_next_c = coef_q.p0 + t1_q + mult_data_i;
`endif

    // Coefficients, first partial product and output sample
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            coef_q   <= '0;
            t1_q     <= '0;
            y_data_q <= '0;
        end else begin
            if (load_c) begin
                coef_q.p0 <= p0_i;
                coef_q.p1 <= p1_i;
                coef_q.p2 <= p2_i;
            end
            if (cap_t1_c) begin
                t1_q <= mult_data_i;
            end
            if (cap_y_c) begin
                y_data_q <= y_next_c;
            end
        end
    end

    intpol2_d4_mult_ctrl_xi_gen u_xi_gen (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .clr_i    (load_c),
        .step_i   (step_c),
        .last_c_o (last_c),
        .xi_o     (mult_xi_o),
        .xi2_o    (mult_xi2_o)
    );

    assign coef_ready_o = coef_ready_q;
    assign sel_mult_o   = sel_mult_q;
    assign y_valid_o    = y_valid_q;
    assign busy_o       = busy_q;
    assign y_data_o     = y_data_q;
    assign mult_p1_o    = coef_q.p1;
    assign mult_p2_o    = coef_q.p2;

endmodule

// File: tb/tb_intpol2_d4_mult_ctrl.sv
// Closed-loop bench for intpol2_d4_mult_ctrl with a behavioural multiplier
// and an arithmetic reference model of y = p0 + p1*k/STEPS + p2*k^2/STEPS^2.
module tb_intpol2_d4_mult_ctrl;
    import intpol2_d4_mult_ctrl_pkg::*;

    localparam int unsigned PW = 2 * W;
    localparam int unsigned EW = 72;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rstn;
    logic                coef_valid, coef_ready;
    logic signed [W-1:0] p0, p1, p2;
    logic                sel;
    logic signed [W-1:0] mxi, mxi2, mp1, mp2, mdata;
    logic                y_valid, y_ready;
    logic signed [W-1:0] y_data;
    logic                busy;
    logic                sat;

    int checks   = 0;
    int failures = 0;

    logic signed [W-1:0] obs_y[$];
    logic                obs_sat[$];
    int                  lat;
    bit                  tmo;

    intpol2_d4_mult_ctrl dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .coef_valid_i (coef_valid),
        .coef_ready_o (coef_ready),
        .p0_i         (p0),
        .p1_i         (p1),
        .p2_i         (p2),
        .sel_mult_o   (sel),
        .mult_xi_o    (mxi),
        .mult_xi2_o   (mxi2),
        .mult_p1_o    (mp1),
        .mult_p2_o    (mp2),
        .mult_data_i  (mdata),
        .y_valid_o    (y_valid),
        .y_ready_i    (y_ready),
        .y_data_o     (y_data),
`ifdef INTPOL2_SAT_EN
        .sat_flag_o   (sat),
`endif
        .busy_o       (busy)
    );
`ifndef INTPOL2_SAT_EN
    assign sat = 1'b0;
`endif

    // Stand-in for the external shared multiplier: (a*b) >>> M_BITS
    function automatic logic signed [W-1:0] mul_q(input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
        logic signed [PW-1:0] pr;
        pr = PW'(a) * PW'(b);
        return W'(pr >>> M_BITS);
    endfunction

    always_comb mdata = sel ? mul_q(mp2, mxi2) : mul_q(mp1, mxi);

    // Reference: floor terms, exact wide sum, then wrap or clamp
    function automatic logic signed [W-1:0] ref_y(input logic signed [W-1:0] a0,
                                                  input logic signed [W-1:0] a1,
                                                  input logic signed [W-1:0] a2,
                                                  input int k, output logic s);
        logic signed [EW-1:0] e;
        e = EW'(a0) + ((EW'(a1) * EW'(k)) >>> LOG2_STEPS)
                    + ((EW'(a2) * EW'(k * k)) >>> (2 * LOG2_STEPS));
        s = 1'b0;
`ifdef INTPOL2_SAT_EN
        begin
            logic signed [EW-1:0] hi, lo;
            hi = (EW'(1) <<< (W - 1)) - EW'(1);
            lo = -(EW'(1) <<< (W - 1));
            if (e > hi) begin s = 1'b1; e = hi; end
            else if (e < lo) begin s = 1'b1; e = lo; end
        end
`endif
        return e[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] rnd_w();
        return W'({$urandom(), $urandom()});
    endfunction

    // Pushes one coefficient set and records accepted samples (no checking)
    task automatic run_set(input logic signed [W-1:0] a0, input logic signed [W-1:0] a1,
                           input logic signed [W-1:0] a2, input int ready_pct);
        int cyc;
        int n;
        obs_y.delete();
        obs_sat.delete();
        lat = -1;
        tmo = 1'b0;
        p0 = a0; p1 = a1; p2 = a2;
        coef_valid = 1'b1;
        cyc = 0;
        while (!coef_ready && cyc < 50) begin @(negedge clk); cyc++; end
        if (!coef_ready) begin
            tmo = 1'b1;
            coef_valid = 1'b0;
            return;
        end
        @(negedge clk);
        coef_valid = 1'b0;
        n = 1;
        cyc = 0;
        while (obs_y.size() < STEPS && cyc < 400) begin
            y_ready = ($urandom_range(99) < ready_pct);
            if (y_valid && lat < 0) lat = n;
            if (y_valid && y_ready) begin
                obs_y.push_back(y_data);
                obs_sat.push_back(sat);
            end
            @(negedge clk);
            n++;
            cyc++;
        end
        if (obs_y.size() < STEPS) tmo = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b0; coef_valid = 1'b0; y_ready = 1'b0;
        p0 = '0; p1 = '0; p2 = '0;
        repeat (2) @(negedge clk);
        checks++; if (coef_ready !== 1'b1) begin failures++; $display("FAIL reset_coef_ready got=%b exp=1", coef_ready); end
        checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL reset_y_valid got=%b exp=0", y_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (sel !== 1'b0) begin failures++; $display("FAIL reset_sel got=%b exp=0", sel); end
        checks++; if (y_data !== '0) begin failures++; $display("FAIL reset_y_data got=%0d exp=0", y_data); end
        checks++; if (mxi !== '0 || mxi2 !== '0) begin failures++; $display("FAIL reset_xi got=%0d/%0d exp=0/0", mxi, mxi2); end
        rstn = 1'b1;
    endtask

    task automatic test_linear();
        logic signed [W-1:0] exp_v[STEPS];
        exp_v[0] = '0;
        exp_v[1] = 34'sd536870912;
        exp_v[2] = 34'sd1073741824;
        exp_v[3] = 34'sd1610612736;
        @(negedge clk);
        run_set('0, 34'sd2147483648, '0, 100);
        checks++; if (tmo) begin failures++; $display("FAIL linear_timeout got=%0d samples exp=%0d", obs_y.size(), STEPS); end
        checks++; if (lat != 3) begin failures++; $display("FAIL linear_latency got=%0d exp=3", lat); end
        foreach (obs_y[i]) begin
            checks++;
            if (obs_y[i] !== exp_v[i]) begin failures++; $display("FAIL linear_y k=%0d got=%0d exp=%0d", i, obs_y[i], exp_v[i]); end
        end
        checks++; if (coef_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL linear_idle got ready=%b busy=%b exp 1/0", coef_ready, busy); end
    endtask

    task automatic test_quadratic();
        logic signed [W-1:0] exp_v[STEPS];
        exp_v[0] = '0;
        exp_v[1] = 34'sd134217728;
        exp_v[2] = 34'sd536870912;
        exp_v[3] = 34'sd1207959552;
        @(negedge clk);
        run_set('0, '0, 34'sd2147483648, 100);
        checks++; if (tmo) begin failures++; $display("FAIL quad_timeout got=%0d samples exp=%0d", obs_y.size(), STEPS); end
        foreach (obs_y[i]) begin
            checks++;
            if (obs_y[i] !== exp_v[i]) begin failures++; $display("FAIL quad_y k=%0d got=%0d exp=%0d", i, obs_y[i], exp_v[i]); end
        end
    endtask

    task automatic test_stall();
        logic signed [W-1:0] a0, a1, a2, ey;
        logic es;
        int cyc;
        a0 = rnd_w() >>> 4; a1 = rnd_w() >>> 4; a2 = rnd_w() >>> 4;
        ey = ref_y(a0, a1, a2, 1, es);
        @(negedge clk);
        p0 = a0; p1 = a1; p2 = a2; coef_valid = 1'b1; y_ready = 1'b1;
        cyc = 0;
        while (!coef_ready && cyc < 50) begin @(negedge clk); cyc++; end
        @(negedge clk);
        coef_valid = 1'b0;
        cyc = 0;
        while (!y_valid && cyc < 20) begin @(negedge clk); cyc++; end
        checks++; if (y_valid !== 1'b1) begin failures++; $display("FAIL stall_k0_valid got=%b exp=1", y_valid); end
        @(negedge clk);
        y_ready = 1'b0;
        cyc = 0;
        while (!y_valid && cyc < 20) begin @(negedge clk); cyc++; end
        for (int i = 0; i < 5; i++) begin
            checks++; if (y_valid !== 1'b1) begin failures++; $display("FAIL stall_valid cyc=%0d got=%b exp=1", i, y_valid); end
            checks++; if (y_data !== ey) begin failures++; $display("FAIL stall_y cyc=%0d got=%0d exp=%0d", i, y_data, ey); end
            checks++; if (sel !== 1'b0) begin failures++; $display("FAIL stall_sel cyc=%0d got=%b exp=0", i, sel); end
            checks++; if (mxi !== 34'sd536870912) begin failures++; $display("FAIL stall_xi cyc=%0d got=%0d exp=536870912", i, mxi); end
            @(negedge clk);
        end
        y_ready = 1'b1;
        cyc = 0;
        while (!coef_ready && cyc < 40) begin @(negedge clk); cyc++; end
        checks++; if (coef_ready !== 1'b1) begin failures++; $display("FAIL stall_drain got=%b exp=1", coef_ready); end
    endtask

    task automatic test_sat();
        logic signed [W-1:0] a0, ey;
        logic es;
        a0 = 34'sh1_FFFF_FFFF;
        @(negedge clk);
        run_set(a0, 34'sd2147483648, '0, 100);
        checks++; if (tmo) begin failures++; $display("FAIL sat_timeout got=%0d samples exp=%0d", obs_y.size(), STEPS); end
`ifdef INTPOL2_SAT_EN
        ey = 34'sh1_FFFF_FFFF;
`else
        ey = -34'sd8053063681;
`endif
        checks++; if (obs_y.size() > 1 && obs_y[1] !== ey) begin failures++; $display("FAIL sat_k1 got=%0d exp=%0d", obs_y[1], ey); end
        foreach (obs_y[i]) begin
            ey = ref_y(a0, 34'sd2147483648, '0, i, es);
            checks++;
            if (obs_y[i] !== ey) begin failures++; $display("FAIL sat_y k=%0d got=%0d exp=%0d", i, obs_y[i], ey); end
`ifdef INTPOL2_SAT_EN
            checks++;
            if (obs_sat[i] !== es) begin failures++; $display("FAIL sat_flag k=%0d got=%b exp=%b", i, obs_sat[i], es); end
`endif
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        @(negedge clk);
        p0 = 34'sd1000; p1 = 34'sd2147483648; p2 = 34'sd2147483648;
        coef_valid = 1'b1; y_ready = 1'b1;
        cyc = 0;
        while (!coef_ready && cyc < 50) begin @(negedge clk); cyc++; end
        @(negedge clk);
        coef_valid = 1'b0;
        @(negedge clk);
        checks++; if (sel !== 1'b1) begin failures++; $display("FAIL rmid_in_mul_b got sel=%b exp=1", sel); end
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL rmid_y_valid got=%b exp=0", y_valid); end
        checks++; if (coef_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rmid_idle got ready=%b busy=%b exp 1/0", coef_ready, busy); end
        rstn = 1'b1;
        @(negedge clk);
        run_set('0, 34'sd2147483648, '0, 100);
        checks++; if (tmo) begin failures++; $display("FAIL rmid_timeout got=%0d samples exp=%0d", obs_y.size(), STEPS); end
        checks++; if (obs_y.size() > 1 && (obs_y[0] !== '0 || obs_y[1] !== 34'sd536870912)) begin
            failures++; $display("FAIL rmid_restart got=%0d,%0d exp=0,536870912", obs_y[0], obs_y[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic signed [W-1:0] a[3], b[3], ey;
        logic signed [W-1:0] got[$];
        logic es;
        int hs, hs2_cyc, last_out_cyc;
        for (int i = 0; i < 3; i++) begin a[i] = rnd_w() >>> 3; b[i] = rnd_w() >>> 3; end
        hs = 0; hs2_cyc = -1; last_out_cyc = -1;
        @(negedge clk);
        p0 = a[0]; p1 = a[1]; p2 = a[2]; coef_valid = 1'b1;
        for (int c = 0; c < 150; c++) begin
            y_ready = ($urandom_range(99) < 70);
            if (coef_valid && coef_ready) begin
                hs++;
                if (hs == 2) hs2_cyc = c;
            end
            if (y_valid && y_ready) begin
                got.push_back(y_data);
                if (got.size() == STEPS) last_out_cyc = c;
            end
            @(negedge clk);
            if (hs == 1) begin p0 = b[0]; p1 = b[1]; p2 = b[2]; end
            if (hs >= 2) coef_valid = 1'b0;
        end
        checks++; if (hs != 2) begin failures++; $display("FAIL b2b_handshakes got=%0d exp=2", hs); end
        checks++; if (got.size() != 2 * STEPS) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got.size(), 2 * STEPS); end
        checks++; if (hs2_cyc != last_out_cyc + 1) begin failures++; $display("FAIL b2b_gap got=%0d exp=%0d", hs2_cyc, last_out_cyc + 1); end
        foreach (got[i]) begin
            if (i < STEPS) ey = ref_y(a[0], a[1], a[2], i, es);
            else           ey = ref_y(b[0], b[1], b[2], i - STEPS, es);
            checks++;
            if (got[i] !== ey) begin failures++; $display("FAIL b2b_y idx=%0d got=%0d exp=%0d", i, got[i], ey); end
        end
    endtask

    task automatic test_random();
        logic signed [W-1:0] a0, a1, a2, ey;
        logic es;
        for (int s = 0; s < 12; s++) begin
            a0 = rnd_w(); a1 = rnd_w(); a2 = rnd_w();
            if (s % 2 == 0) begin a0 = a0 >>> 3; a1 = a1 >>> 3; a2 = a2 >>> 3; end
            @(negedge clk);
            run_set(a0, a1, a2, int'($urandom_range(30, 100)));
            checks++; if (tmo) begin failures++; $display("FAIL rand_timeout set=%0d got=%0d samples", s, obs_y.size()); end
            foreach (obs_y[i]) begin
                ey = ref_y(a0, a1, a2, i, es);
                checks++;
                if (obs_y[i] !== ey) begin failures++; $display("FAIL rand_y set=%0d k=%0d got=%0d exp=%0d", s, i, obs_y[i], ey); end
`ifdef INTPOL2_SAT_EN
                checks++;
                if (obs_sat[i] !== es) begin failures++; $display("FAIL rand_sat set=%0d k=%0d got=%b exp=%b", s, i, obs_sat[i], es); end
`endif
            end
        end
    endtask

    initial begin
        rstn = 1'b0; coef_valid = 1'b0; y_ready = 1'b0;
        p0 = '0; p1 = '0; p2 = '0;
        test_reset();
        test_linear();
        test_quadratic();
        test_stall();
        test_sat();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
